ext_rd_port_arbiter: RTL and testbench

//   Shares the single external read port (addr / rd_en / data) between the

---
 rtl/ext_rd_port_arbiter_pkg.sv | 32 +++
 rtl/ext_rd_port_arbiter_if.sv | 30 +++
 rtl/ext_rd_port_arbiter_rd_tag_pipe.sv | 32 +++
 rtl/ext_rd_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ext_rd_port_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_rd_port_arbiter_pkg.sv
// Shared types and constants for the external read-port arbiter: requester
// indices, FSM state encoding and the return-path tag record.
package ext_rd_port_arbiter_pkg;

    localparam int REQ_INSTR   = 0;
    localparam int REQ_FEATURE = 1;
    localparam int REQ_WEIGHT  = 2;
    localparam int N_REQ_DEF   = REQ_WEIGHT + 1;
    localparam int OWNER_W     = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               last;
    } rd_tag_t;

    function automatic rd_tag_t tag_make(input logic valid,
                                         input logic [OWNER_W-1:0] owner,
                                         input logic last);
        rd_tag_t t;
        t.valid = valid;
        t.owner = owner;
        t.last  = last;
        return t;
    endfunction

endpackage

// File: rtl/ext_rd_port_arbiter_if.sv
// Request/grant, external memory and return-data signals of the read-port
// arbiter; master = requesters plus memory, slave = arbiter.
interface ext_rd_port_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 128
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*LEN_W-1:0]  req_len;
    logic [N_REQ-1:0]        grant;
    logic                    busy;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rd_en;
    logic [DATA_W-1:0]       mem_rd_data;
    logic [DATA_W-1:0]       rd_data;
    logic [N_REQ-1:0]        rd_valid;
    logic [N_REQ-1:0]        rd_last;

    modport master (
        output req, req_addr, req_len, mem_rd_data,
        input  grant, busy, mem_addr, mem_rd_en, rd_data, rd_valid, rd_last
    );

    modport slave (
        input  req, req_addr, req_len, mem_rd_data,
        output grant, busy, mem_addr, mem_rd_en, rd_data, rd_valid, rd_last
    );
endinterface

// File: rtl/ext_rd_port_arbiter_rd_tag_pipe.sv
// Shift register carrying one {valid, owner, last} tag per read strobe so the
// tag emerges in the same cycle as the matching external read data.
module ext_rd_port_arbiter_rd_tag_pipe
    import ext_rd_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset discards every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ext_rd_port_arbiter.sv
// Round-robin burst arbiter for the shared external read port: grants one
// burst at a time, issues sequential addresses and routes tagged return beats.
module ext_rd_port_arbiter
    import ext_rd_port_arbiter_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 8,
    parameter int DATA_W     = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ext_rd_port_arbiter_if.slave  bus
);

    arb_state_e         state_q;
    logic [OWNER_W-1:0] rr_ptr_q;
    logic [OWNER_W-1:0] owner_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   remain_q;
    logic               issue_q;
    logic [DATA_W-1:0]  rd_data_q;

    logic [ADDR_W-1:0]  req_addr_s [N_REQ];
    logic [LEN_W-1:0]   req_len_s  [N_REQ];
    logic [OWNER_W-1:0] cand_s;
    logic [OWNER_W-1:0] pick_idx_s;
    logic               pick_found_s;
    logic [OWNER_W-1:0] next_ptr_s;
    logic [N_REQ-1:0]   grant_s;
    rd_tag_t            tag_in_s;
    rd_tag_t            tag_out_s;
    logic [N_REQ-1:0]   rd_valid_s;
    logic [N_REQ-1:0]   rd_last_s;
    logic [DATA_W-1:0]  rd_data_s;

    // Unpack the flat per-requester address/length buses.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_addr_s[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
            req_len_s[i]  = bus.req_len[i*LEN_W +: LEN_W];
        end
    end

    // First active request at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = OWNER_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!pick_found_s && bus.req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
        if (pick_idx_s == OWNER_W'(N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = pick_idx_s + OWNER_W'(1);
        end
    end

    // Grant is a same-cycle pulse while idle; it is forced low during reset.
    always_comb begin
        grant_s = '0;
        if (!rst && (state_q == ST_IDLE) && pick_found_s) begin
            grant_s[pick_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // IDLE/ISSUE burst FSM with address counter and registered strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= OWNER_W'(REQ_INSTR);
            owner_q  <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            issue_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        rr_ptr_q <= next_ptr_s;
                        owner_q  <= pick_idx_s;
                        if (req_len_s[pick_idx_s] != '0) begin
                            state_q  <= ST_ISSUE;
                            issue_q  <= 1'b1;
                            addr_q   <= req_addr_s[pick_idx_s];
                            remain_q <= req_len_s[pick_idx_s] - LEN_W'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    // remain_q counts beats still to go after the current one.
                    if (remain_q == '0) begin
                        state_q <= ST_IDLE;
                        issue_q <= 1'b0;
                    end else begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        remain_q <= remain_q - LEN_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    issue_q <= 1'b0;
                end
            endcase
        end
    end

    assign tag_in_s = tag_make(issue_q, owner_q, issue_q && (remain_q == '0));

    ext_rd_port_arbiter_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in_s),
        .tag_o (tag_out_s)
    );

    // Decode the emerging tag into one-hot valid/last and select the data.
    always_comb begin
        rd_valid_s = '0;
        rd_last_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_out_s.valid && (tag_out_s.owner == OWNER_W'(i))) begin
                rd_valid_s[i] = 1'b1;
                rd_last_s[i]  = tag_out_s.last;
            end else begin
                rd_valid_s[i] = 1'b0;
                rd_last_s[i]  = 1'b0;
            end
        end
        if (tag_out_s.valid) begin
            rd_data_s = bus.mem_rd_data;
        end else begin
            rd_data_s = rd_data_q;
        end
    end

    // Hold the most recently delivered beat between valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_s;
        end
    end

    assign bus.grant     = grant_s;
    assign bus.busy      = issue_q;
    assign bus.mem_rd_en = issue_q;
    assign bus.mem_addr  = addr_q;
    assign bus.rd_data   = rd_data_s;
    assign bus.rd_valid  = rd_valid_s;
    assign bus.rd_last   = rd_last_s;

endmodule

// File: tb/tb_ext_rd_port_arbiter.sv
// Directed bench for ext_rd_port_arbiter with a scoreboard of expected
// strobe addresses and return beats.
module tb_ext_rd_port_arbiter;
    import ext_rd_port_arbiter_pkg::*;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 128;
    localparam int LAT    = 3;

    typedef struct packed {
        logic [N_REQ-1:0]  vld;
        logic [N_REQ-1:0]  last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;

    beat_t             beat_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int                due_q  [$];
    logic [DATA_W-1:0] mem_pipe [LAT];

    ext_rd_port_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    ext_rd_port_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .RD_LATENCY(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 16'h5A3C, 16'h1234, a, 16'hBEEF, ~a, a};
    endfunction

    // External memory: data for the address strobed LAT cycles earlier.
    always @(posedge clk) begin
        cyc_cnt     <= cyc_cnt + 1;
        mem_pipe[0] <= mem_word(bus.mem_addr);
        for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign bus.mem_rd_data = mem_pipe[LAT-1];

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int owner, input logic [ADDR_W-1:0] a, input int len);
        logic [ADDR_W-1:0] ak;
        beat_t             b;
        for (int k = 0; k < len; k++) begin
            ak     = a + ADDR_W'(k);
            b.vld  = N_REQ'(1) << owner;
            b.last = (k == len - 1) ? b.vld : '0;
            b.data = mem_word(ak);
            addr_q.push_back(ak);
            beat_q.push_back(b);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        beat_t b;
        if (rst === 1'b0) begin
            if (bus.mem_rd_en) begin
                if (addr_q.size() > 0) begin
                    chk("mem_addr", DATA_W'(bus.mem_addr), DATA_W'(addr_q.pop_front()));
                    due_q.push_back(cyc_cnt + LAT);
                end else begin
                    chk("spurious_strobe", DATA_W'(bus.mem_rd_en), DATA_W'(1'b0));
                end
            end
            if (|bus.rd_valid) begin
                if (beat_q.size() > 0 && due_q.size() > 0) begin
                    b = beat_q.pop_front();
                    chk("rd_latency", DATA_W'(cyc_cnt), DATA_W'(due_q.pop_front()));
                    chk("rd_valid", DATA_W'(bus.rd_valid), DATA_W'(b.vld));
                    chk("rd_last", DATA_W'(bus.rd_last), DATA_W'(b.last));
                    chk("rd_data", bus.rd_data, b.data);
                end else begin
                    chk("spurious_beat", DATA_W'(bus.rd_valid), DATA_W'(0));
                end
            end else begin
                chk("rd_last_idle", DATA_W'(bus.rd_last), DATA_W'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic [N_REQ-1:0] g, output int n);
        n = 0;
        while (bus.grant == '0 && n < 40) begin
            step();
            n++;
        end
        g = bus.grant;
    endtask

    task automatic request(input int idx, input logic [ADDR_W-1:0] a, input int len,
                           input logic [N_REQ-1:0] exp_g, input string tag);
        logic [N_REQ-1:0] g;
        int               n;
        bus.req_addr[idx*ADDR_W +: ADDR_W] = a;
        bus.req_len[idx*LEN_W +: LEN_W]    = LEN_W'(len);
        bus.req[idx]                       = 1'b1;
        #1;
        wait_grant(g, n);
        chk(tag, DATA_W'(g), DATA_W'(exp_g));
        push_burst(idx, a, len);
        step();
        bus.req[idx] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((addr_q.size() != 0 || beat_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk(tag, DATA_W'(addr_q.size() + beat_q.size()), DATA_W'(0));
        repeat (4) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, DATA_W'(bus.grant), DATA_W'(0));
        chk({tag, "_busy"}, DATA_W'(bus.busy), DATA_W'(0));
        chk({tag, "_mem_rd_en"}, DATA_W'(bus.mem_rd_en), DATA_W'(0));
        chk({tag, "_mem_addr"}, DATA_W'(bus.mem_addr), DATA_W'(0));
        chk({tag, "_rd_data"}, bus.rd_data, DATA_W'(0));
        chk({tag, "_rd_valid"}, DATA_W'(bus.rd_valid), DATA_W'(0));
        chk({tag, "_rd_last"}, DATA_W'(bus.rd_last), DATA_W'(0));
    endtask

    initial begin
        logic [N_REQ-1:0] g;
        int               n;
        int               order [4];
        order = '{0, 1, 2, 0};

        rst          = 1'b1;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_len  = '0;
        #1;
        check_all_zero("reset");
        bus.req = 3'b111;
        #1;
        chk("reset_grant_masked", DATA_W'(bus.grant), DATA_W'(0));
        bus.req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        step();

        // Single 4-beat burst from the feature fetcher.
        request(REQ_FEATURE, 16'h0010, 4, 3'b010, "t1_grant");
        chk("t1_busy", DATA_W'(bus.busy), DATA_W'(1'b1));
        chk("t1_first_addr", DATA_W'(bus.mem_addr), DATA_W'(16'h0010));
        drain("t1_drain");
        chk("t1_rd_data_hold", bus.rd_data, mem_word(16'h0013));

        // Zero-length burst: grant pulse only.
        request(REQ_WEIGHT, 16'h0200, 0, 3'b100, "t4_grant");
        chk("t4_busy", DATA_W'(bus.busy), DATA_W'(0));
        chk("t4_no_strobe", DATA_W'(bus.mem_rd_en), DATA_W'(0));
        repeat (6) step();

        // All three requesting, round-robin order with one bubble between bursts.
        bus.req_addr = {16'h3000, 16'h2000, 16'h1000};
        bus.req_len  = {8'd2, 8'd2, 8'd2};
        bus.req      = 3'b111;
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, n);
            chk("t2_grant_order", DATA_W'(g), DATA_W'(N_REQ'(1) << order[i]));
            chk("t2_bubble", DATA_W'(bus.mem_rd_en), DATA_W'(0));
            if (i > 0) chk("t2_gap", DATA_W'(n), DATA_W'(2));
            push_burst(order[i], 16'h1000 * ADDR_W'(order[i] + 1), 2);
            step();
        end
        bus.req = '0;
        drain("t2_drain");

        // Address wraps at the top of the address space.
        request(REQ_INSTR, 16'hFFFE, 4, 3'b001, "t3_grant");
        drain("t3_drain");

        // Back-to-back bursts from two owners.
        request(REQ_INSTR, 16'h0400, 2, 3'b001, "t5_grant_a");
        bus.req_addr[REQ_WEIGHT*ADDR_W +: ADDR_W] = 16'h0800;
        bus.req_len[REQ_WEIGHT*LEN_W +: LEN_W]    = 8'd3;
        bus.req[REQ_WEIGHT]                       = 1'b1;
        #1;
        wait_grant(g, n);
        chk("t5_grant_b", DATA_W'(g), DATA_W'(3'b100));
        chk("t5_gap", DATA_W'(n), DATA_W'(2));
        push_burst(REQ_WEIGHT, 16'h0800, 3);
        step();
        bus.req = '0;
        drain("t5_drain");

        // Reset in the middle of an 8-beat burst.
        request(REQ_FEATURE, 16'h0100, 8, 3'b010, "t6_grant");
        step();
        rst = 1'b1;
        addr_q.delete();
        beat_q.delete();
        due_q.delete();
        #1;
        check_all_zero("t6_reset");
        repeat (2) step();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (8) step();
        bus.req_addr = {16'h0C00, 16'h0B00, 16'h0A00};
        bus.req_len  = {8'd1, 8'd1, 8'd1};
        bus.req      = 3'b111;
        #1;
        wait_grant(g, n);
        chk("t6_grant_after_reset", DATA_W'(g), DATA_W'(3'b001));
        push_burst(REQ_INSTR, 16'h0A00, 1);
        step();
        bus.req = '0;
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
